i2s_sample_tx: RTL
==================

I2S_SAMPLE_TX -- requirements
Module: i2s_sample_tx

Interface
REQ-001 Parameter BCLK_HALF, 8: clk cycles per half BCLK period, >=2.
REQ-002 Parameter SLOT_BITS, 32: BCLK periods per channel slot, >=17; one frame is 2*SLOT_BITS BCLK periods.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 sample_in  in  16  signed PCM sample offered by the flash music reader.
REQ-006 sample_valid  in  1  sample_in is valid this cycle.
REQ-007 play  in  1  level; 1 = transmit, 0 = stop at the next frame end.
REQ-008 mute  in  1  level; 1 = transmit zeros while still consuming samples.
REQ-009 data_over  out  1  one-clk pulse when a sample moves into the shifter; this is the request for the next sample.
REQ-010 AUD_BCLK  out  1  bit clock.
REQ-011 AUD_DACLRCK  out  1  word select; 0 = left, 1 = right.
REQ-012 AUD_DACDAT  out  1  serial data, MSB first.
REQ-013 underrun_cnt  out  8  saturating count of frames started with no new sample.

Function
REQ-014 Holding register hold_reg/hold_full SHALL capture sample_in when sample_valid=1 and hold_full=0; sample_valid while hold_full=1 and no load occurs is ignored.
REQ-015 Divider div_cnt SHALL count 0..BCLK_HALF-1 and toggle AUD_BCLK at the terminal count in RUN; it is held at 0 otherwise.
REQ-016 Falling BCLK edge SHALL be the clk cycle in which AUD_BCLK toggles 1->0.
REQ-017 On each falling BCLK edge, bit_cnt SHALL advance mod 2*SLOT_BITS; AUD_DACLRCK, AUD_DACDAT and bit_cnt SHALL update only in that cycle.
REQ-018 AUD_DACLRCK SHALL be 0 for bit_cnt < SLOT_BITS and 1 otherwise.
REQ-019 Slot position p = bit_cnt mod SLOT_BITS. AUD_DACDAT SHALL be 0 at p=0, shifter bit 16-p for p=1..16, and 0 for p>=17. This is the I2S one-bit delay.
REQ-020 Both slots SHALL carry the same 16-bit shifter value (mono duplicated to stereo).
REQ-021 Frame start is the falling edge where bit_cnt wraps to 0, and also the PRIME->RUN transition.
REQ-022 At frame start with hold_full=1: shifter <= hold_reg (or 0 if mute=1), hold_full cleared, data_over=1 in the next clk cycle only.
REQ-023 At frame start with hold_full=0: shifter keeps its previous value (0 if mute=1), underrun_cnt increments and saturates at 255, and data_over stays 0.
REQ-024 sample_valid in the same cycle as a frame-start load SHALL be captured into hold_reg, leaving hold_full=1.
REQ-025 The state machine SHALL be IDLE -> PRIME when play=1.
REQ-026 The state machine SHALL be PRIME -> RUN when hold_full=1: load as in REQ-022, bit_cnt=0, AUD_BCLK=0.
REQ-027 The state machine SHALL be RUN -> IDLE when play=0 at a frame-end wrap; no load and no data_over occur in that case.
REQ-028 play=0 in PRIME SHALL return the block to IDLE.
REQ-029 In IDLE and PRIME, AUD_BCLK, AUD_DACLRCK and AUD_DACDAT SHALL be 0, and div_cnt and bit_cnt SHALL be 0.
REQ-030 The first BCLK falling edge after entering RUN SHALL occur 2*BCLK_HALF clk cycles later, with bit_cnt advancing to 1.

Reset
REQ-031 Reset SHALL apply in any state, including mid-frame, and take priority over all other inputs.
REQ-032 Reset SHALL force: state=IDLE; AUD_BCLK=0; AUD_DACLRCK=0; AUD_DACDAT=0; data_over=0; underrun_cnt=0; hold_full=0; shifter, div_cnt, bit_cnt=0.

Verification (BCLK_HALF=2, SLOT_BITS=32)
REQ-033 Basic frame: play=1, one sample_valid with 16'hA5C3.
- Required: data_over pulses once.
- Left slot p=1..16 shows 1010010111000011, right slot repeats it, and p=0 and p>=17 are 0.
- Frame length is 256 clk.
REQ-034 Underrun: feed 16'h1234, then no further samples for 3 frames.
- Required: 16'h1234 is repeated for 3 frames, underrun_cnt=3, and data_over pulses only once.
- Also hold sample_valid low for 300 frames: underrun_cnt stays at 255.
REQ-035 Backpressure: sample_valid held 1 with incrementing data.
- Required: exactly one data_over per 256 clk.
- Transmitted sequence has no gaps or duplicates, and each captured value is the one present in the load cycle.
REQ-036 Mute: mute=1 with 16'h7FFF supplied.
- Required: AUD_DACDAT stays 0 and data_over still pulses every frame.
REQ-037 Stop: play dropped mid-frame.
- Required: the current frame completes, then IDLE with all outputs 0.
- The pending hold_reg is retained and is the first sample sent after play returns to 1.
REQ-038 Reset mid-frame at bit_cnt=20.
- Required: the next cycle has all outputs 0 and underrun_cnt=0.
- play=1 afterwards waits in PRIME for a new sample.

Source files
------------

// File: rtl/i2s_sample_tx.sv
// Purpose : I2S transmitter; one 16-bit mono PCM sample per frame, sent identically in both slots.
// Latency : a held sample reaches the shifter at the next frame start; data_over follows one clk later.
// Backpres: single-entry hold register; sample_valid is ignored while it is full and not being drained.
//
// Ports:
//   clk, Reset     : system clock, synchronous active-high reset
//   sample_in/_valid : PCM sample offer from the music reader
//   play, mute     : transmit enable (stops at frame end) / send zeros while still consuming
//   data_over      : one-clk request for the next sample, raised after each shifter load
//   AUD_BCLK/AUD_DACLRCK/AUD_DACDAT : I2S bit clock, word select (0 = left), serial data MSB first
//   underrun_cnt   : saturating count of frames started without a fresh sample
module i2s_sample_tx #(
  parameter int BCLK_HALF = 8,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  input  logic        play,
  input  logic        mute,
  output logic        data_over,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT,
  output logic [7:0]  underrun_cnt
);

  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [15:0]   hold_reg;
  logic          hold_full;
  logic [15:0]   shifter;

  logic          div_tc;
  logic          bclk_fall;
  logic          frame_wrap;
  logic          frame_start;
  logic          do_load;
  logic          do_under;
  logic [BW-1:0] bit_nxt;
  logic [BW-1:0] slot_pos;
  logic          dat_nxt;

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    dat_nxt     = 1'b0;

    div_tc     = (state == RUN) && (div_cnt == DW'(BCLK_HALF - 1));
    // A terminal count while BCLK is high is the 1->0 edge: the only cycle serial outputs move.
    bclk_fall  = div_tc && AUD_BCLK;
    frame_wrap = bclk_fall && (bit_cnt == BW'(2 * SLOT_BITS - 1));
    bit_nxt    = frame_wrap ? '0 : bit_cnt + BW'(1);
    slot_pos   = (bit_nxt >= BW'(SLOT_BITS)) ? bit_nxt - BW'(SLOT_BITS) : bit_nxt;

    // Position 0 is the I2S one-bit delay; the 16 sample bits follow, then zero padding.
    if (slot_pos >= BW'(1) && slot_pos <= BW'(16))
      dat_nxt = shifter[4'(16 - int'(slot_pos))];

    case (state)
      IDLE:  if (play) state_nxt = PRIME;
      PRIME: begin
        if (!play) begin
          state_nxt = IDLE;
        end else if (hold_full) begin
          state_nxt   = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        if (frame_wrap) begin
          if (play) frame_start = 1'b1;
          else      state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    do_load  = frame_start && hold_full;
    do_under = frame_start && !hold_full;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      data_over    <= 1'b0;
      hold_reg     <= '0;
      hold_full    <= 1'b0;
      shifter      <= '0;
      underrun_cnt <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      AUD_BCLK     <= 1'b0;
      AUD_DACLRCK  <= 1'b0;
      AUD_DACDAT   <= 1'b0;
    end else begin
      data_over <= do_load;

      // The hold register refills in the same cycle it drains into the shifter.
      if (sample_valid && (!hold_full || do_load)) begin
        hold_reg  <= sample_in;
        hold_full <= 1'b1;
      end else if (do_load) begin
        hold_full <= 1'b0;
      end

      if (do_load)
        shifter <= mute ? '0 : hold_reg;
      else if (do_under && mute)
        shifter <= '0;

      if (do_under && underrun_cnt != 8'hFF)
        underrun_cnt <= underrun_cnt + 8'd1;

      // Entering RUN restarts the bit clock from a known low phase at bit 0.
      if (state != RUN || state_nxt != RUN) begin
        div_cnt     <= '0;
        bit_cnt     <= '0;
        AUD_BCLK    <= 1'b0;
        AUD_DACLRCK <= 1'b0;
        AUD_DACDAT  <= 1'b0;
      end else if (div_tc) begin
        div_cnt  <= '0;
        AUD_BCLK <= ~AUD_BCLK;
        if (bclk_fall) begin
          bit_cnt     <= bit_nxt;
          AUD_DACLRCK <= (bit_nxt >= BW'(SLOT_BITS));
          AUD_DACDAT  <= dat_nxt;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule
